// File: rtl/router_sync_param.sv
// rtl/router_sync_param.sv - header-FSM to output-FIFO synchroniser with per-port read timeouts
module router_sync_param #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30,
    parameter int CNT_W     = 5
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 detect_add,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 write_enb_reg,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 addr_err
);

    // One extra bit so NUM_PORTS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  LP_NUM_PORTS = (ADDR_W + 1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] LP_LAST      = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0] r_addr_reg;
    logic              r_addr_valid;
    logic              r_addr_err;
    logic              w_in_range;

    assign w_in_range = ({1'b0, data_in} < LP_NUM_PORTS);
    assign addr_err   = r_addr_err;
    assign vld_out    = ~empty;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr_reg   <= '0;
            r_addr_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_addr_err <= detect_add && !w_in_range;
            if (detect_add) begin
                r_addr_reg   <= data_in;
                r_addr_valid <= w_in_range;
            end
        end
    end

    // Steering always uses the previously latched address, even when a new header arrives this cycle.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_addr_valid && (r_addr_reg == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [CNT_W-1:0] r_cnt;
        logic             r_soft_reset;

        assign soft_reset[g] = r_soft_reset;

        // A read on the expiring cycle wins: counter clears with no pulse.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_cnt        <= '0;
                r_soft_reset <= 1'b0;
            end else if (!vld_out[g] || read_enb[g]) begin
                r_cnt        <= '0;
                r_soft_reset <= 1'b0;
            end else if (r_cnt == LP_LAST) begin
                r_cnt        <= '0;
                r_soft_reset <= 1'b1;
            end else begin
                r_cnt        <= r_cnt + CNT_W'(1);
                r_soft_reset <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_sync_param.sv
// tb/tb_router_sync_param.sv - directed self-checking bench for router_sync_param
module tb_router_sync_param;

    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       addr_err;

    int n_cmp = 0;
    int n_err = 0;

    router_sync_param #(
        .NUM_PORTS(3),
        .ADDR_W   (2),
        .TIMEOUT  (30),
        .CNT_W    (5)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .full         (full),
        .empty        (empty),
        .read_enb     (read_enb),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out      (vld_out),
        .soft_reset   (soft_reset),
        .addr_err     (addr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and park on the following falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        detect_add    = 1'b0;
        data_in       = 2'b00;
        write_enb_reg = 1'b1;
        full          = 3'b111;
        empty         = 3'b010;
        read_enb      = 3'b000;
        step(2);
        #1;
        chk("rst_write_enb", write_enb, 3'b000);
        chk("rst_fifo_full", {2'b00, fifo_full}, 3'b000);
        chk("rst_addr_err", {2'b00, addr_err}, 3'b000);
        chk("rst_soft_reset", soft_reset, 3'b000);
        chk("rst_vld_out", vld_out, 3'b101);

        empty         = 3'b111;
        write_enb_reg = 1'b0;
        resetn        = 1'b1;
        step(1);

        detect_add = 1'b1;
        data_in    = 2'b01;
        step(1);
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b010;
        #1;
        chk("p1_write_enb", write_enb, 3'b010);
        chk("p1_fifo_full_set", {2'b00, fifo_full}, 3'b001);
        chk("p1_addr_err", {2'b00, addr_err}, 3'b000);
        full = 3'b101;
        #1;
        chk("p1_fifo_full_clr", {2'b00, fifo_full}, 3'b000);
        write_enb_reg = 1'b0;

        step(1);
        detect_add = 1'b1;
        data_in    = 2'b11;
        step(1);
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b111;
        #1;
        chk("bad_addr_err_hi", {2'b00, addr_err}, 3'b001);
        chk("bad_write_enb", write_enb, 3'b000);
        chk("bad_fifo_full", {2'b00, fifo_full}, 3'b000);
        step(1);
        chk("bad_addr_err_lo", {2'b00, addr_err}, 3'b000);
        write_enb_reg = 1'b0;

        empty = 3'b110;
        #1;
        chk("to_vld_out", vld_out, 3'b001);
        step(29);
        chk("to_before_1st", soft_reset, 3'b000);
        step(1);
        chk("to_1st_pulse", soft_reset, 3'b001);
        step(1);
        chk("to_pulse_drop", soft_reset, 3'b000);
        step(28);
        chk("to_before_2nd", soft_reset, 3'b000);
        step(1);
        chk("to_2nd_pulse", soft_reset, 3'b001);
        empty = 3'b111;
        step(2);

        empty = 3'b110;
        step(29);
        read_enb = 3'b001;
        step(1);
        chk("rd_expiry_suppressed", soft_reset, 3'b000);
        read_enb = 3'b000;
        step(29);
        chk("rd_before_pulse", soft_reset, 3'b000);
        step(1);
        chk("rd_pulse_after_read", soft_reset, 3'b001);
        empty = 3'b111;
        step(2);

        empty = 3'b000;
        step(29);
        chk("all_before", soft_reset, 3'b000);
        step(1);
        chk("all_simultaneous", soft_reset, 3'b111);
        empty = 3'b111;
        step(2);

        detect_add = 1'b1;
        data_in    = 2'b00;
        step(1);
        data_in       = 2'b10;
        write_enb_reg = 1'b1;
        #1;
        chk("ovl_old_addr", write_enb, 3'b001);
        step(1);
        detect_add = 1'b0;
        #1;
        chk("ovl_new_addr", write_enb, 3'b100);

        empty = 3'b110;
        step(20);
        chk("mid_write_enb", write_enb, 3'b100);
        resetn = 1'b0;
        #1;
        chk("mid_rst_write_enb", write_enb, 3'b000);
        chk("mid_rst_vld_out", vld_out, 3'b001);
        step(1);
        resetn = 1'b1;
        #1;
        chk("post_rst_write_enb", write_enb, 3'b000);
        step(29);
        chk("post_rst_before", soft_reset, 3'b000);
        step(1);
        chk("post_rst_pulse", soft_reset, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_sync_param.md
Name: router_sync_param

Overview:
- Parametrised synchroniser between the router's header-decode FSM and its NUM_PORTS output FIFOs.
- Latches the destination address on detect_add and steers write enables to that FIFO.
- Muxes that FIFO's full flag back to the FSM and exposes per-port valid flags.
- Runs an independent timeout per port that pulses soft_reset when a destination leaves its data unread; also flags packets addressed to non-existent ports.

Parameters:
- NUM_PORTS, 3: number of output channels/FIFOs (2..2^ADDR_W).
- ADDR_W, 2: width of the address field in data_in.
- TIMEOUT, 30: consecutive unread-valid cycles before soft_reset pulses (2..2^CNT_W-1).
- CNT_W, 5: width of each per-port timeout counter.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- detect_add  in  1  header-byte strobe from FSM; sample data_in as address.
- data_in  in  ADDR_W  destination address field of header.
- write_enb_reg  in  1  FSM request to write current byte to selected FIFO.
- full  in  NUM_PORTS  per-FIFO full flags.
- empty  in  NUM_PORTS  per-FIFO empty flags.
- read_enb  in  NUM_PORTS  per-port read strobes from destinations.
- write_enb  out  NUM_PORTS  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the selected FIFO.
- vld_out  out  NUM_PORTS  per-port data-available flags.
- soft_reset  out  NUM_PORTS  per-port one-cycle FIFO flush pulse.
- addr_err  out  1  one-cycle pulse: header addressed a non-existent port.

Behaviour:
- Reset (resetn=0, asynchronous): addr_reg=0, addr_valid=0, all counters=0, soft_reset=0, addr_err=0.
  - write_enb=0 during reset.
  - vld_out stays combinational (=~empty) regardless of reset.
  - Reset mid-packet aborts steering immediately; the next packet needs a fresh detect_add.
- Address latch: each rising edge with detect_add=1 loads addr_reg<=data_in and addr_valid<=(data_in<NUM_PORTS).
  - detect_add=0 holds both.
- addr_err: registered; =1 for exactly the cycle after an edge that sampled detect_add=1 with data_in>=NUM_PORTS; otherwise 0.
- write_enb (combinational):
  - If write_enb_reg && addr_valid, only bit addr_reg is high.
  - Otherwise all bits are 0.
  - detect_add and write_enb_reg together in one cycle: write_enb uses the previously latched addr_reg.
- fifo_full (combinational): full[addr_reg] when addr_valid, else 0. A packet to an invalid address therefore drains with no writes and no stall.
- vld_out[i] = ~empty[i] (combinational, zero latency).
- Timeout, per port i, evaluated each rising edge in priority order:
  1. vld_out[i]=0 or read_enb[i]=1: cnt[i]<=0, soft_reset[i]<=0.
  2. Else if cnt[i]==TIMEOUT-1: soft_reset[i]<=1, cnt[i]<=0.
  3. Else: cnt[i]<=cnt[i]+1, soft_reset[i]<=0.
- Timeout consequences:
  - soft_reset[i] rises after the TIMEOUT-th consecutive edge with vld_out[i]=1 and read_enb[i]=0.
  - It is high for one cycle only.
  - If the port stays stuck, it repeats every TIMEOUT cycles.
  - A read in the same cycle the count would expire takes priority: no pulse, counter clears.
- Ports are fully independent; simultaneous timeouts on several ports pulse simultaneously.
- soft_reset has no effect on addr_reg or addr_valid.

Test Plan:
- Reset, then detect_add=1, data_in=2'b01 for one cycle; write_enb_reg=1 -> write_enb=3'b010. With full=3'b010 -> fifo_full=1; with full=3'b101 -> fifo_full=0.
- detect_add=1, data_in=2'b11 (NUM_PORTS=3) -> addr_err=1 for exactly one cycle; with write_enb_reg=1, write_enb=3'b000 and fifo_full=0 even with full=3'b111.
- empty=3'b110, read_enb=0 held -> vld_out=3'b001; soft_reset[0]=1 one cycle after the 30th edge, 0 next cycle, again 30 cycles later; soft_reset[2:1] stay 0.
- As above, but read_enb[0]=1 pulsed on the 29th cycle -> no soft_reset; counter restarts; pulse comes 30 cycles after the read.
- detect_add=1, data_in=2'b10 and write_enb_reg=1 in the same cycle after address 2'b00 latched -> write_enb=3'b001 that cycle, 3'b100 the next.
- Assert resetn=0 mid-count (cnt=20) with write_enb active -> write_enb=0 and counters clear immediately; after release, soft_reset needs a full 30 cycles.
